imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter IMEM_W, default 14: byte-address width of the shared instruction memory.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 m0_req_i  input  1  requester 0 (fetch) read request.
REQ-005 m0_addr_i  input  IMEM_W  requester 0 byte address.
REQ-006 m0_gnt_o  output  1  requester 0 request accepted this cycle.
REQ-007 m0_rvalid_o  output  1  requester 0 response valid.
REQ-008 m0_rdata_o  output  32  requester 0 response word.
REQ-009 m0_rerr_o  output  1  requester 0 response misaligned-address error.
REQ-010 m0_rready_i  input  1  requester 0 accepts response.
REQ-011 m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_rerr_o, m1_rready_i SHALL match REQ-004..REQ-010 for requester 1 (debug/loader read port).
REQ-012 mem_addr_o  output  IMEM_W  address to the combinational-read instruction memory.
REQ-013 mem_rdata_i  input  32  word returned combinationally for mem_addr_o.

Function
REQ-014 Each requester SHALL own a one-entry response slot; slot is free when rvalid_o=0 or (rvalid_o=1 and rready_i=1) in the same cycle.
REQ-015 Requester n SHALL be eligible when mn_req_i=1 and its slot is free.
REQ-016 At most one grant per cycle; mn_gnt_o SHALL be combinational from eligibility and the round-robin pointer.
REQ-017 Only one eligible: that requester SHALL be granted.
REQ-018 Both eligible: the requester not granted most recently SHALL be granted; pointer SHALL update to the granted requester on every grant.
REQ-019 After reset, pointer SHALL indicate requester 1, so requester 0 wins the first contention.
REQ-020 mem_addr_o SHALL equal the granted requester's address during a grant cycle and all-zero otherwise.
REQ-021 On a grant edge, mem_rdata_i SHALL be captured into the granted slot and mn_rvalid_o SHALL assert the following cycle (latency 1).
REQ-022 mn_rvalid_o, mn_rdata_o, mn_rerr_o SHALL hold stable while rvalid_o=1 and rready_i=0.
REQ-023 rvalid_o=1 with rready_i=1 and no new grant: rvalid_o SHALL deassert next cycle.
REQ-024 rvalid_o=1 with rready_i=1 and a new grant in the same cycle: slot SHALL reload, rvalid_o stays 1, new data next cycle (back-to-back throughput of one word per cycle per requester).
REQ-025 Granted address with addr[1:0]!=0: slot SHALL capture rdata=32'h0 and rerr=1; memory still addressed, data discarded.
REQ-026 Aligned grant: rerr SHALL be 0.
REQ-027 Requester address and req MAY change freely after the grant cycle; no ungranted request is latched.
REQ-028 A requester with a full, unaccepted slot SHALL never be granted and SHALL not block the other requester.
REQ-029 req deasserted while response pending SHALL not cancel the pending response.

Reset
REQ-030 While rst_i=1: m0/m1_gnt_o=0, m0/m1_rvalid_o=0, m0/m1_rdata_o=0, m0/m1_rerr_o=0, mem_addr_o=0, pointer=requester 1.
REQ-031 Reset asserted mid-operation SHALL discard all pending responses immediately (asynchronously); no response SHALL appear after deassertion without a new grant.
REQ-032 First grant SHALL be possible in the first cycle after rst_i deasserts.

Verification
REQ-033 Memory model word[i]=32'hA000_0000+i; m0 req addr 0x0010, rready=1 -> gnt same cycle, next cycle m0_rvalid=1, rdata=32'hA000_0004, rerr=0.
REQ-034 m0 and m1 both req every cycle, rready=1, from reset -> grants alternate m0,m1,m0,m1; each requester gets one response every 2 cycles.
REQ-035 m0 req addr 0x0008, rready=0 for 3 cycles while req stays high -> single grant, rdata=32'hA000_0002 held 3 cycles, no further m0 grant; m1 requests granted every cycle meanwhile.
REQ-036 m1 req addr 0x0006 -> m1_rvalid=1 next cycle with rerr=1, rdata=0.
REQ-037 m0 streaming addrs 0x0,0x4,0x8 with rready=1 -> gnt 3 consecutive cycles, rvalid 3 consecutive cycles, rdata A000_0000/0001/0002.
REQ-038 rst_i pulsed while m0_rvalid=1 and rready=0 -> rvalid drops immediately; after release, no rvalid until a new grant.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle between the two instruction-memory requesters, the arbiter and the
// shared combinational-read instruction memory.
interface imem_arbiter_if #(
    parameter int IMEM_W = 14
);
    logic              m0_req_i;
    logic [IMEM_W-1:0] m0_addr_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [31:0]       m0_rdata_o;
    logic              m0_rerr_o;
    logic              m0_rready_i;

    logic              m1_req_i;
    logic [IMEM_W-1:0] m1_addr_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [31:0]       m1_rdata_o;
    logic              m1_rerr_o;
    logic              m1_rready_i;

    logic [IMEM_W-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_addr_i, m0_rready_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_rerr_o,
        input  m1_req_i, m1_addr_i, m1_rready_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_rerr_o,
        output mem_addr_o,
        input  mem_rdata_i
    );

    modport master (
        output m0_req_i, m0_addr_i, m0_rready_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_rerr_o,
        output m1_req_i, m1_addr_i, m1_rready_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_rerr_o,
        input  mem_addr_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester round-robin arbiter for a shared combinational-read instruction
// memory, with a one-entry registered response slot per requester.
module imem_arbiter #(
    parameter int IMEM_W = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imem_arbiter_if.slave bus
);

    function automatic logic misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

    logic              ptr_r;   // 1: requester 1 was granted most recently
    logic              m0_free_s, m1_free_s;
    logic              m0_elig_s, m1_elig_s;
    logic              m0_gnt_s, m1_gnt_s;
    logic [IMEM_W-1:0] mem_addr_s;
    logic              grant_err_s;

    logic              m0_rvalid_r, m1_rvalid_r;
    logic [31:0]       m0_rdata_r, m1_rdata_r;
    logic              m0_rerr_r, m1_rerr_r;

    // Eligibility, round-robin grant selection and memory address mux.
    always_comb begin
        m0_free_s  = !m0_rvalid_r || bus.m0_rready_i;
        m1_free_s  = !m1_rvalid_r || bus.m1_rready_i;
        m0_elig_s  = bus.m0_req_i && m0_free_s;
        m1_elig_s  = bus.m1_req_i && m1_free_s;
        m0_gnt_s   = 1'b0;
        m1_gnt_s   = 1'b0;
        mem_addr_s = {IMEM_W{1'b0}};
        if (rst_i) begin
            m0_gnt_s = 1'b0;
            m1_gnt_s = 1'b0;
        end else if (m0_elig_s && (!m1_elig_s || ptr_r)) begin
            m0_gnt_s   = 1'b1;
            mem_addr_s = bus.m0_addr_i;
        end else if (m1_elig_s) begin
            m1_gnt_s   = 1'b1;
            mem_addr_s = bus.m1_addr_i;
        end else begin
            mem_addr_s = {IMEM_W{1'b0}};
        end
        grant_err_s = misaligned(mem_addr_s[1:0]);
    end

    // Round-robin pointer follows every grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r <= 1'b1;
        end else if (m0_gnt_s) begin
            ptr_r <= 1'b0;
        end else if (m1_gnt_s) begin
            ptr_r <= 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Requester 0 response slot; a grant reloads it even while it is being drained.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m0_rvalid_r <= 1'b0;
            m0_rdata_r  <= 32'h0000_0000;
            m0_rerr_r   <= 1'b0;
        end else if (m0_gnt_s) begin
            m0_rvalid_r <= 1'b1;
            m0_rdata_r  <= grant_err_s ? 32'h0000_0000 : bus.mem_rdata_i;
            m0_rerr_r   <= grant_err_s;
        end else if (bus.m0_rready_i) begin
            m0_rvalid_r <= 1'b0;
        end else begin
            m0_rvalid_r <= m0_rvalid_r;
        end
    end

    // Requester 1 response slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m1_rvalid_r <= 1'b0;
            m1_rdata_r  <= 32'h0000_0000;
            m1_rerr_r   <= 1'b0;
        end else if (m1_gnt_s) begin
            m1_rvalid_r <= 1'b1;
            m1_rdata_r  <= grant_err_s ? 32'h0000_0000 : bus.mem_rdata_i;
            m1_rerr_r   <= grant_err_s;
        end else if (bus.m1_rready_i) begin
            m1_rvalid_r <= 1'b0;
        end else begin
            m1_rvalid_r <= m1_rvalid_r;
        end
    end

    assign bus.m0_gnt_o    = m0_gnt_s;
    assign bus.m1_gnt_o    = m1_gnt_s;
    assign bus.mem_addr_o  = mem_addr_s;
    assign bus.m0_rvalid_o = m0_rvalid_r;
    assign bus.m0_rdata_o  = m0_rdata_r;
    assign bus.m0_rerr_o   = m0_rerr_r;
    assign bus.m1_rvalid_o = m1_rvalid_r;
    assign bus.m1_rdata_o  = m1_rdata_r;
    assign bus.m1_rerr_o   = m1_rerr_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: a queue-based requester model
// predicts grants and responses; a separate monitor checks every response slot.
module tb_imem_arbiter;

    localparam int IMEM_W = 14;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   last_granted;
    resp_t q0[$];
    resp_t q1[$];

    imem_arbiter_if #(.IMEM_W(IMEM_W)) bus ();

    imem_arbiter #(.IMEM_W(IMEM_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Memory model: word[i] = A000_0000 + i
    assign bus.mem_rdata_i = 32'hA000_0000 + {20'd0, bus.mem_addr_o[IMEM_W-1:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t expect_resp(input logic [IMEM_W-1:0] a);
        resp_t r;
        r.err  = (a % 4) != 0;
        r.data = r.err ? 32'h0 : 32'hA000_0000 + 32'(a / 4);
        return r;
    endfunction

    // One clock cycle: drive at negedge, predict and check grants, commit at posedge.
    task automatic cycle(input logic r0, input logic [IMEM_W-1:0] a0, input logic y0,
                         input logic r1, input logic [IMEM_W-1:0] a1, input logic y1);
        logic e0, e1, g0, g1;
        logic [IMEM_W-1:0] ea;
        bus.m0_req_i = r0; bus.m0_addr_i = a0; bus.m0_rready_i = y0;
        bus.m1_req_i = r1; bus.m1_addr_i = a1; bus.m1_rready_i = y1;
        #1;
        e0 = r0 && (q0.size() == 0 || y0);
        e1 = r1 && (q1.size() == 0 || y1);
        if (e0 && e1) begin
            g0 = (last_granted == 1);
            g1 = !g0;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        ea = g0 ? a0 : (g1 ? a1 : '0);
        chk("m0_gnt", 32'(bus.m0_gnt_o), 32'(g0));
        chk("m1_gnt", 32'(bus.m1_gnt_o), 32'(g1));
        chk("mem_addr", 32'(bus.mem_addr_o), 32'(ea));
        @(posedge clk);
        if (g0) begin
            q0.push_back(expect_resp(a0));
            last_granted = 0;
        end
        if (g1) begin
            q1.push_back(expect_resp(a1));
            last_granted = 1;
        end
        @(negedge clk);
    endtask

    // Monitor: response slots must match the scoreboard; accepted responses are popped.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("m0_rvalid", 32'(bus.m0_rvalid_o), 32'(q0.size() != 0));
                if (bus.m0_rvalid_o && q0.size() != 0) begin
                    chk("m0_rdata", bus.m0_rdata_o, q0[0].data);
                    chk("m0_rerr", 32'(bus.m0_rerr_o), 32'(q0[0].err));
                    if (bus.m0_rready_i) void'(q0.pop_front());
                end
                chk("m1_rvalid", 32'(bus.m1_rvalid_o), 32'(q1.size() != 0));
                if (bus.m1_rvalid_o && q1.size() != 0) begin
                    chk("m1_rdata", bus.m1_rdata_o, q1[0].data);
                    chk("m1_rerr", 32'(bus.m1_rerr_o), 32'(q1[0].err));
                    if (bus.m1_rready_i) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        logic r0, r1, y0, y1;
        logic [IMEM_W-1:0] a0, a1;
        total = 0;
        bad = 0;
        last_granted = 1;
        rst = 1'b0;
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 14'h0010; bus.m0_rready_i = 1'b1;
        bus.m1_req_i = 1'b1; bus.m1_addr_i = 14'h0020; bus.m1_rready_i = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_m0_gnt", 32'(bus.m0_gnt_o), 32'd0);
        chk("rst_m1_gnt", 32'(bus.m1_gnt_o), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        chk("rst_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
        chk("rst_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd0);
        chk("rst_m0_rdata", bus.m0_rdata_o, 32'd0);
        chk("rst_m1_rdata", bus.m1_rdata_o, 32'd0);
        chk("rst_m0_rerr", 32'(bus.m0_rerr_o), 32'd0);
        chk("rst_m1_rerr", 32'(bus.m1_rerr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Contention from reset: m0 first, then alternation
        for (int i = 0; i < 6; i++) cycle(1'b1, 14'(4 * i), 1'b1, 1'b1, 14'(14'h0100 + 4 * i), 1'b1);
        // Single aligned fetch
        cycle(1'b1, 14'h0010, 1'b1, 1'b0, 14'h0, 1'b1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);
        // m0 stalled response; m1 streams meanwhile
        cycle(1'b1, 14'h0008, 1'b0, 1'b1, 14'h0200, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 14'h0008, 1'b0, 1'b1, 14'(14'h0204 + 4 * i), 1'b1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);
        // Misaligned debug read
        cycle(1'b0, 14'h0, 1'b1, 1'b1, 14'h0006, 1'b1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);
        // Back-to-back streaming
        for (int i = 0; i < 3; i++) cycle(1'b1, 14'(4 * i), 1'b1, 1'b0, 14'h0, 1'b1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);

        // Reset while m0 holds an unaccepted response
        cycle(1'b1, 14'h0030, 1'b0, 1'b0, 14'h0, 1'b1);
        bus.m0_req_i = 1'b1;
        bus.m0_rready_i = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
        chk("midrst_m0_gnt", 32'(bus.m0_gnt_o), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        q0.delete();
        q1.delete();
        last_granted = 1;
        @(negedge clk);
        bus.m0_req_i = 1'b0;
        rst = 1'b0;
        cycle(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 1'b0);
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);
        cycle(1'b1, 14'h0040, 1'b1, 1'b1, 14'h0044, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r0 = $urandom_range(0, 3) != 0;
            r1 = $urandom_range(0, 3) != 0;
            y0 = $urandom_range(0, 9) < 7;
            y1 = $urandom_range(0, 9) < 7;
            a0 = 14'($urandom_range(0, 16383));
            a1 = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 3) != 0) a0[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) a1[1:0] = 2'b00;
            cycle(r0, a0, y0, r1, a1, y1);
        end
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0, 14'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
